// File: rtl/uio_tx_pkg.sv
// rtl/uio_tx_pkg.sv - shared state encoding and bus constants for the uio parallel transmitter
package uio_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ABORT   = 3'd4
  } tx_state_e;

  localparam logic [7:0] BUS_RELEASE = 8'h00;
  localparam logic [7:0] BUS_DRIVE   = 8'hFF;

  // Saturating increment for the per-state cycle counter
  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/uio_tx_fifo.sv
// rtl/uio_tx_fifo.sv - DEPTH x 8 synchronous byte FIFO feeding the transmitter
module uio_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A push while full is accepted only when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wptr_d  = do_push ? (wptr_q + PTR_ONE) : wptr_q;
  assign rptr_d  = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;

  // Pointer and storage update; reset discards all queued bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/uio_par_tx.sv
// rtl/uio_par_tx.sv - four-phase strobe/ack byte transmitter driving the uio pad bus
module uio_par_tx
  import uio_tx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SETUP   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       stb_o,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       err_o,
  input  logic       err_clr_i,
  output logic [7:0] tx_count_o
);

  localparam logic [7:0] SETUP_C   = 8'(SETUP);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  tx_state_e  state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] uio_out_q;
  logic [7:0] uio_oe_q;
  logic       stb_q;
  logic       err_q;
  logic [7:0] tx_count_q;
  logic       ack_meta_q;
  logic       ack_s_q;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  assign fifo_push = valid_i && ready_o;
  // A stale ack left high by the receiver must clear before a new byte is offered
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && !ack_s_q;
  assign cnt_d     = cnt_inc(cnt_q);

  uio_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Two-flop synchroniser for the asynchronous receiver acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack_i;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Handshake FSM with registered pad outputs; uio_out_q doubles as the data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h00;
      uio_out_q  <= BUS_RELEASE;
      uio_oe_q   <= BUS_RELEASE;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      tx_count_q <= 8'h00;
    end else begin
      // Clear first so a timeout in the same cycle overrides it
      if (err_clr_i) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            uio_out_q <= fifo_rdata;
            uio_oe_q  <= BUS_DRIVE;
            cnt_q     <= 8'h00;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_d == SETUP_C) begin
            stb_q   <= 1'b1;
            cnt_q   <= 8'h00;
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_STROBE: begin
          if (ack_s_q) begin
            stb_q   <= 1'b0;
            cnt_q   <= 8'h00;
            state_q <= ST_RELEASE;
          end else if (cnt_d == TIMEOUT_C) begin
            err_q     <= 1'b1;
            stb_q     <= 1'b0;
            uio_oe_q  <= BUS_RELEASE;
            uio_out_q <= BUS_RELEASE;
            cnt_q     <= 8'h00;
            state_q   <= ST_ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RELEASE: begin
          if (!ack_s_q) begin
            tx_count_q <= tx_count_q + 8'd1;
            uio_oe_q   <= BUS_RELEASE;
            uio_out_q  <= BUS_RELEASE;
            cnt_q      <= 8'h00;
            state_q    <= ST_IDLE;
          end else if (cnt_d == TIMEOUT_C) begin
            err_q     <= 1'b1;
            uio_oe_q  <= BUS_RELEASE;
            uio_out_q <= BUS_RELEASE;
            cnt_q     <= 8'h00;
            state_q   <= ST_ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ABORT: begin
          cnt_q   <= 8'h00;
          state_q <= ST_IDLE;
        end
        default: begin
          stb_q     <= 1'b0;
          uio_oe_q  <= BUS_RELEASE;
          uio_out_q <= BUS_RELEASE;
          cnt_q     <= 8'h00;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o    = !fifo_full;
  assign busy_o     = (state_q != ST_IDLE) || !fifo_empty;
  assign uio_out    = uio_out_q;
  assign uio_oe     = uio_oe_q;
  assign stb_o      = stb_q;
  assign err_o      = err_q;
  assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_uio_par_tx.sv
// tb/tb_uio_par_tx.sv - directed self-checking bench for uio_par_tx
`timescale 1ns/1ps
module tb_uio_par_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       stb_o;
  logic       ack_i;
  logic       busy_o;
  logic       err_o;
  logic       err_clr_i;
  logic [7:0] tx_count_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_cnt  = 8'h00;

  always #5 clk = ~clk;

  uio_par_tx #(
    .DEPTH   (4),
    .SETUP   (2),
    .TIMEOUT (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .uio_out    (uio_out),
    .uio_oe     (uio_oe),
    .stb_o      (stb_o),
    .ack_i      (ack_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .err_clr_i  (err_clr_i),
    .tx_count_o (tx_count_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (!ready_o && n < 2000) begin
      tick();
      n++;
    end
    ok = ready_o;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic serve_byte(input int d_rise, input int d_fall, output logic [7:0] seen, output bit ok);
    int n;
    ok   = 1'b0;
    seen = 8'h00;
    n = 0;
    while (!stb_o && n < 1000) begin tick(); n++; end
    if (!stb_o) return;
    seen = uio_out;
    repeat (d_rise) tick();
    ack_i = 1'b1;
    n = 0;
    while (stb_o && n < 1000) begin tick(); n++; end
    if (stb_o) begin ack_i = 1'b0; return; end
    repeat (d_fall) tick();
    ack_i = 1'b0;
    n = 0;
    while (uio_oe != 8'h00 && n < 1000) begin tick(); n++; end
    ok = (uio_oe == 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; ack_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) tick();
    n_checks++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe got=%h exp=00", uio_oe); end
    n_checks++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", uio_out); end
    n_checks++; if (stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb got=%b exp=0", stb_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
    n_checks++; if (tx_count_o !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", tx_count_o); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++; if (uio_oe !== 8'h00 || busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got oe=%h busy=%b exp oe=00 busy=0", uio_oe, busy_o); end
  endtask

  task automatic test_single();
    int n = 0;
    int setup_n = 0;
    data_i = 8'hA5; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    while (!stb_o && n < 50) begin
      if (uio_oe == 8'hFF && uio_out == 8'hA5) setup_n++;
      tick();
      n++;
    end
    n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL single_stb_rise got=%b exp=1", stb_o); end
    n_checks++; if (setup_n < 2) begin n_fail++; $display("FAIL single_setup_cycles got=%0d exp>=2", setup_n); end
    n_checks++; if (uio_oe !== 8'hFF || uio_out !== 8'hA5) begin n_fail++; $display("FAIL single_data_at_stb got oe=%h out=%h exp oe=ff out=a5", uio_oe, uio_out); end
    repeat (3) tick();
    ack_i = 1'b1;
    n = 0;
    while (stb_o && n < 50) begin tick(); n++; end
    n_checks++; if (stb_o !== 1'b0 || uio_oe !== 8'hFF) begin n_fail++; $display("FAIL single_release got stb=%b oe=%h exp stb=0 oe=ff", stb_o, uio_oe); end
    repeat (3) tick();
    ack_i = 1'b0;
    n = 0;
    while (uio_oe != 8'h00 && n < 50) begin tick(); n++; end
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL single_count got=%h exp=%h", tx_count_o, exp_cnt); end
    n_checks++; if (uio_oe !== 8'h00 || busy_o !== 1'b0 || stb_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got oe=%h busy=%b stb=%b exp 00/0/0", uio_oe, busy_o, stb_o); end
  endtask

  task automatic test_burst();
    logic [7:0] got [6];
    bit         okp [6];
    bit         okr [6];
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1), okp[i]);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL burst_ready_drop got=%b exp=0", ready_o); end
    fork
      push_byte(8'h06, okp[5]);
      for (int k = 0; k < 6; k++) serve_byte(1, 1, got[k], okr[k]);
    join
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (!okr[i] || got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL burst_byte%0d got=%h ok=%b exp=%h", i, got[i], okr[i], 8'(i + 1)); end
    end
    exp_cnt = exp_cnt + 8'd6;
    n_checks++; if (tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL burst_count got=%h exp=%h", tx_count_o, exp_cnt); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL burst_idle got busy=%b exp=0", busy_o); end
  endtask

  task automatic test_timeout();
    int         n = 0;
    bit         ok;
    logic [7:0] seen;
    push_byte(8'h3C, ok);
    while (!stb_o && n < 50) begin tick(); n++; end
    n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL timeout_stb_rise got=%b exp=1", stb_o); end
    n = 0;
    while (stb_o && n < 400) begin tick(); n++; end
    n_checks++; if (n != 255) begin n_fail++; $display("FAIL timeout_strobe_len got=%0d exp=255", n); end
    n_checks++; if (err_o !== 1'b1 || stb_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err got err=%b stb=%b exp err=1 stb=0", err_o, stb_o); end
    n_checks++; if (tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL timeout_count got=%h exp=%h", tx_count_o, exp_cnt); end
    tick();
    n_checks++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL timeout_oe got=%h exp=00", uio_oe); end
    push_byte(8'h5A, ok);
    serve_byte(2, 2, seen, ok);
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (!ok || seen !== 8'h5A) begin n_fail++; $display("FAIL timeout_next_byte got=%h ok=%b exp=5a", seen, ok); end
    n_checks++; if (tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL timeout_next_count got=%h exp=%h", tx_count_o, exp_cnt); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky got=%b exp=1", err_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_stale_ack();
    bit         ok;
    logic [7:0] seen;
    ack_i = 1'b1;
    repeat (3) tick();
    push_byte(8'h77, ok);
    repeat (5) tick();
    n_checks++; if (uio_oe !== 8'h00 || stb_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL stale_hold got oe=%h stb=%b busy=%b exp 00/0/1", uio_oe, stb_o, busy_o); end
    ack_i = 1'b0;
    tick();
    n_checks++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL stale_cycle1 got oe=%h exp=00", uio_oe); end
    tick();
    n_checks++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL stale_cycle2 got oe=%h exp=00", uio_oe); end
    tick();
    n_checks++; if (uio_oe !== 8'hFF || uio_out !== 8'h77) begin n_fail++; $display("FAIL stale_start got oe=%h out=%h exp ff/77", uio_oe, uio_out); end
    serve_byte(1, 1, seen, ok);
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (!ok || seen !== 8'h77 || tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL stale_complete got byte=%h ok=%b cnt=%h exp 77/1/%h", seen, ok, tx_count_o, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit ok;
    push_byte(8'h99, ok);
    push_byte(8'h11, ok);
    push_byte(8'h22, ok);
    while (!stb_o && n < 50) begin tick(); n++; end
    n_checks++; if (stb_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_stb_rise got=%b exp=1", stb_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (uio_oe !== 8'h00 || stb_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_bus got oe=%h stb=%b exp 00/0", uio_oe, stb_o); end
    n_checks++; if (tx_count_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_async_count got=%h exp=00", tx_count_o); end
    repeat (2) tick();
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    repeat (3) tick();
    n_checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || uio_oe !== 8'h00) begin n_fail++; $display("FAIL rstmid_after got ready=%b busy=%b oe=%h exp 1/0/00", ready_o, busy_o, uio_oe); end
  endtask

  task automatic test_wrap();
    bit         okp;
    bit         okr;
    logic [7:0] seen;
    fork
      for (int i = 0; i < 256; i++) push_byte(8'(i), okp);
      for (int j = 0; j < 256; j++) begin
        serve_byte(0, 0, seen, okr);
        n_checks++;
        if (!okr || seen !== 8'(j)) begin n_fail++; $display("FAIL wrap_byte%0d got=%h ok=%b exp=%h", j, seen, okr, 8'(j)); end
      end
    join
    exp_cnt = exp_cnt + 8'd0;
    n_checks++; if (tx_count_o !== 8'h00) begin n_fail++; $display("FAIL wrap_count got=%h exp=00", tx_count_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got busy=%b exp=0", busy_o); end
  endtask

  task automatic test_err_priority();
    int n = 0;
    bit ok;
    push_byte(8'hC3, ok);
    while (!stb_o && n < 50) begin tick(); n++; end
    n_checks++; if (stb_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL prio_start got stb=%b err=%b exp 1/0", stb_o, err_o); end
    err_clr_i = 1'b1;
    n = 0;
    while (stb_o && n < 400) begin tick(); n++; end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL prio_set_over_clear got=%b exp=1", err_o); end
    err_clr_i = 1'b0;
    tick();
    n_checks++; if (err_o !== 1'b1 || tx_count_o !== exp_cnt) begin n_fail++; $display("FAIL prio_after got err=%b cnt=%h exp 1/%h", err_o, tx_count_o, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_stale_ack();
    test_reset_mid();
    test_wrap();
    test_err_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
